// File: rtl/spart_mmio_responder.sv
// spart_mmio_responder
//   Memory-mapped register front end for a serial port. A single-request
//   initiator reads the RX byte FIFO / writes the TX byte FIFO through the
//   data register and polls flags through the status register.
// Ports
//   clk, rst               clock, synchronous active-high reset
//   mem_valid_data         request valid (held by the initiator)
//   mem_rw_data            1 = write, 0 = read
//   mem_data_addr [27:0]   request address
//   mem_data_wr   [31:0]   write data (only [7:0] used)
//   mem_data_rd   [31:0]   read data, valid with mem_ready_data
//   mem_ready_data         one-cycle completion pulse
//   rx_byte [7:0], rx_strobe  receiver byte + one-cycle strobe
//   tx_byte [7:0], tx_valid, tx_ready  transmitter handshake (TX FIFO head)
// Status register: bit0 TX not full, bit1 RX not empty, bit2 rd_underflow,
//   bit3 wr_overflow, bit4 rx_overrun; bits 4:2 are sticky, cleared on read.
module spart_mmio_responder #(
  parameter int          DEPTH     = 8,
  parameter logic [27:0] DATA_ADDR = 28'h8000000,
  parameter logic [27:0] STAT_ADDR = 28'h8000001
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_valid_data,
  input  logic        mem_rw_data,
  input  logic [27:0] mem_data_addr,
  input  logic [31:0] mem_data_wr,
  output logic [31:0] mem_data_rd,
  output logic        mem_ready_data,
  input  logic [7:0]  rx_byte,
  input  logic        rx_strobe,
  output logic [7:0]  tx_byte,
  output logic        tx_valid,
  input  logic        tx_ready
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, RESP, DRAIN} state_t;

  state_t         r_state;
  logic [31:0]    r_rd_data;
  logic           r_ready;
  logic [7:0]     r_rx_mem [DEPTH];
  logic [7:0]     r_tx_mem [DEPTH];
  logic [AW-1:0]  r_rx_rd, r_rx_wr, r_tx_rd, r_tx_wr;
  logic [CW-1:0]  r_rx_cnt, r_tx_cnt;
  logic           r_rd_unf, r_wr_ovf, r_rx_ovr;

  logic        w_accept, w_is_data, w_is_stat;
  logic        w_rx_empty, w_rx_full, w_tx_empty, w_tx_full;
  logic        w_rx_push, w_rx_pop, w_tx_push, w_tx_pop;
  logic        w_rd_unf, w_wr_ovf, w_rx_ovr, w_stat_rd;
  logic [31:0] w_status, w_result;
  logic        w_unused;

  // Only the low byte of write data reaches the TX FIFO.
  assign w_unused = ^mem_data_wr[31:8];

  assign w_accept  = (r_state == IDLE) && mem_valid_data;
  assign w_is_data = (mem_data_addr == DATA_ADDR);
  assign w_is_stat = (mem_data_addr == STAT_ADDR);

  assign w_rx_empty = (r_rx_cnt == '0);
  assign w_rx_full  = (r_rx_cnt == FULL_CNT);
  assign w_tx_empty = (r_tx_cnt == '0);
  assign w_tx_full  = (r_tx_cnt == FULL_CNT);

  // Full/empty are judged on the pre-edge count: a same-cycle pop never
  // makes room for a push, and an empty TX FIFO never bypasses to tx_byte.
  assign w_rx_push = rx_strobe && !w_rx_full;
  assign w_rx_ovr  = rx_strobe && w_rx_full;
  assign w_rx_pop  = w_accept && !mem_rw_data && w_is_data && !w_rx_empty;
  assign w_rd_unf  = w_accept && !mem_rw_data && w_is_data && w_rx_empty;
  assign w_tx_push = w_accept && mem_rw_data && w_is_data && !w_tx_full;
  assign w_wr_ovf  = w_accept && mem_rw_data && w_is_data && w_tx_full;
  assign w_tx_pop  = !w_tx_empty && tx_ready;
  assign w_stat_rd = w_accept && !mem_rw_data && w_is_stat;

  assign w_status = {27'b0, r_rx_ovr, r_wr_ovf, r_rd_unf, !w_rx_empty, !w_tx_full};

  always_comb begin
    w_result = 32'b0;
    if (!mem_rw_data && w_is_stat)
      w_result = w_status;
    else if (w_rx_pop)
      w_result = {24'b0, r_rx_mem[r_rx_rd]};
  end

  assign mem_data_rd    = r_rd_data;
  assign mem_ready_data = r_ready;
  assign tx_valid       = !w_tx_empty;
  assign tx_byte        = w_tx_empty ? 8'h00 : r_tx_mem[r_tx_rd];

  // Bus handshake FSM
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_ready   <= 1'b0;
      r_rd_data <= 32'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_ready   <= 1'b0;
          r_rd_data <= 32'b0;
          if (mem_valid_data) begin
            r_ready   <= 1'b1;
            r_rd_data <= w_result;
            r_state   <= RESP;
          end
        end
        RESP: begin
          r_ready   <= 1'b0;
          r_rd_data <= 32'b0;
          r_state   <= DRAIN;
        end
        DRAIN: begin
          r_ready   <= 1'b0;
          r_rd_data <= 32'b0;
          // Wait for the initiator to drop valid so a held request is not re-serviced.
          if (!mem_valid_data) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // FIFO pointers, counts and sticky flags
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rx_rd  <= '0;
      r_rx_wr  <= '0;
      r_rx_cnt <= '0;
      r_tx_rd  <= '0;
      r_tx_wr  <= '0;
      r_tx_cnt <= '0;
      r_rd_unf <= 1'b0;
      r_wr_ovf <= 1'b0;
      r_rx_ovr <= 1'b0;
    end else begin
      if (w_rx_push) r_rx_wr <= r_rx_wr + 1'b1;
      if (w_rx_pop)  r_rx_rd <= r_rx_rd + 1'b1;
      case ({w_rx_push, w_rx_pop})
        2'b10:   r_rx_cnt <= r_rx_cnt + 1'b1;
        2'b01:   r_rx_cnt <= r_rx_cnt - 1'b1;
        default: r_rx_cnt <= r_rx_cnt;
      endcase
      if (w_tx_push) r_tx_wr <= r_tx_wr + 1'b1;
      if (w_tx_pop)  r_tx_rd <= r_tx_rd + 1'b1;
      case ({w_tx_push, w_tx_pop})
        2'b10:   r_tx_cnt <= r_tx_cnt + 1'b1;
        2'b01:   r_tx_cnt <= r_tx_cnt - 1'b1;
        default: r_tx_cnt <= r_tx_cnt;
      endcase
      // A status read clears the flags it captured; an event on that edge wins.
      r_rd_unf <= (r_rd_unf && !w_stat_rd) || w_rd_unf;
      r_wr_ovf <= (r_wr_ovf && !w_stat_rd) || w_wr_ovf;
      r_rx_ovr <= (r_rx_ovr && !w_stat_rd) || w_rx_ovr;
    end
  end

  // FIFO storage (data only, no reset)
  always_ff @(posedge clk) begin
    if (!rst && w_rx_push) r_rx_mem[r_rx_wr] <= rx_byte;
    if (!rst && w_tx_push) r_tx_mem[r_tx_wr] <= mem_data_wr[7:0];
  end

endmodule

// File: tb/tb_spart_mmio_responder.sv
module tb_spart_mmio_responder;

  localparam logic [27:0] DATA_A = 28'h8000000;
  localparam logic [27:0] STAT_A = 28'h8000001;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_valid_data;
  logic        mem_rw_data;
  logic [27:0] mem_data_addr;
  logic [31:0] mem_data_wr;
  logic [31:0] mem_data_rd;
  logic        mem_ready_data;
  logic [7:0]  rx_byte;
  logic        rx_strobe;
  logic [7:0]  tx_byte;
  logic        tx_valid;
  logic        tx_ready;

  int n_tests = 0;
  int n_fail  = 0;

  spart_mmio_responder #(.DEPTH(8), .DATA_ADDR(DATA_A), .STAT_ADDR(STAT_A)) dut (
    .clk(clk), .rst(rst),
    .mem_valid_data(mem_valid_data), .mem_rw_data(mem_rw_data),
    .mem_data_addr(mem_data_addr), .mem_data_wr(mem_data_wr),
    .mem_data_rd(mem_data_rd), .mem_ready_data(mem_ready_data),
    .rx_byte(rx_byte), .rx_strobe(rx_strobe),
    .tx_byte(tx_byte), .tx_valid(tx_valid), .tx_ready(tx_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // One bus transaction; starts and ends at a falling edge with the DUT idle.
  task automatic bus(input logic rw, input logic [27:0] a, input logic [31:0] wd,
                     output logic [31:0] rd);
    int n = 0;
    mem_valid_data = 1'b1;
    mem_rw_data    = rw;
    mem_data_addr  = a;
    mem_data_wr    = wd;
    do begin
      @(negedge clk);
      n++;
    end while (!mem_ready_data && n < 10);
    check("latency", 32'(n), 32'd1);
    rd = mem_data_rd;
    mem_valid_data = 1'b0;
    @(negedge clk);
    check("ready_pulse", 32'(mem_ready_data), 32'd0);
    @(negedge clk);
  endtask

  task automatic strobe(input logic [7:0] b);
    rx_byte   = b;
    rx_strobe = 1'b1;
    @(negedge clk);
    rx_strobe = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    int pulses;
    rst = 1'b1; mem_valid_data = 1'b0; mem_rw_data = 1'b0; mem_data_addr = '0;
    mem_data_wr = '0; rx_byte = '0; rx_strobe = 1'b0; tx_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_ready", 32'(mem_ready_data), 32'd0);
    check("rst_rd", mem_data_rd, 32'd0);
    check("rst_txv", 32'(tx_valid), 32'd0);
    check("rst_txb", 32'(tx_byte), 32'd0);

    bus(1'b0, STAT_A, 32'd0, rd); check("stat_reset", rd, 32'h1);

    // RX byte round trip
    strobe(8'hA5);
    bus(1'b0, STAT_A, 32'd0, rd); check("stat_rx1", rd, 32'h3);
    bus(1'b0, DATA_A, 32'd0, rd); check("rx_data", rd, 32'hA5);
    bus(1'b0, STAT_A, 32'd0, rd); check("stat_rx0", rd, 32'h1);

    // Underflow sticky and clear-on-read
    bus(1'b0, DATA_A, 32'd0, rd); check("unf_data", rd, 32'h0);
    bus(1'b0, STAT_A, 32'd0, rd); check("unf_stat", rd, 32'h5);
    bus(1'b0, STAT_A, 32'd0, rd); check("unf_clr", rd, 32'h1);

    // Status write and unmapped address
    bus(1'b1, STAT_A, 32'hFFFFFFFF, rd); check("stat_wr", rd, 32'h0);
    bus(1'b0, 28'h0000123, 32'd0, rd);   check("other_rd", rd, 32'h0);
    bus(1'b0, STAT_A, 32'd0, rd);        check("other_noeff", rd, 32'h1);

    // TX fill to overflow, then drain in order
    for (int i = 0; i < 9; i++) bus(1'b1, DATA_A, 32'hDEADBE00 | 32'(8'h10 + i), rd);
    bus(1'b0, STAT_A, 32'd0, rd); check("ovf_stat", rd, 32'h8);
    check("ovf_txv", 32'(tx_valid), 32'd1);
    check("ovf_txb", 32'(tx_byte), 32'h10);
    bus(1'b0, STAT_A, 32'd0, rd); check("ovf_clr", rd, 32'h0);
    tx_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("tx_order", 32'(tx_byte), 32'(8'h10 + i));
      @(negedge clk);
    end
    tx_ready = 1'b0;
    check("tx_empty_v", 32'(tx_valid), 32'd0);
    check("tx_empty_b", 32'(tx_byte), 32'd0);

    // Held request: one pulse, one push
    mem_valid_data = 1'b1; mem_rw_data = 1'b1; mem_data_addr = DATA_A; mem_data_wr = 32'h77;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (mem_ready_data) pulses++;
    end
    mem_valid_data = 1'b0;
    @(negedge clk); @(negedge clk);
    check("hold_pulses", 32'(pulses), 32'd1);
    check("hold_txb", 32'(tx_byte), 32'h77);
    tx_ready = 1'b1; @(negedge clk); tx_ready = 1'b0;
    check("hold_one_push", 32'(tx_valid), 32'd0);

    // Simultaneous RX push and bus pop at count 3
    strobe(8'h01); strobe(8'h02); strobe(8'h03);
    rx_byte = 8'h04; rx_strobe = 1'b1;
    mem_valid_data = 1'b1; mem_rw_data = 1'b0; mem_data_addr = DATA_A;
    @(negedge clk);
    rx_strobe = 1'b0;
    check("sim_ready", 32'(mem_ready_data), 32'd1);
    check("sim_pop", mem_data_rd, 32'h01);
    mem_valid_data = 1'b0;
    @(negedge clk); @(negedge clk);
    for (int i = 2; i <= 4; i++) begin
      bus(1'b0, DATA_A, 32'd0, rd); check("sim_order", rd, 32'(i));
    end
    bus(1'b0, STAT_A, 32'd0, rd); check("sim_count", rd, 32'h1);

    // RX overrun
    for (int i = 0; i < 9; i++) strobe(8'(8'h30 + i));
    bus(1'b0, STAT_A, 32'd0, rd); check("ovr_stat", rd, 32'h13);
    bus(1'b0, STAT_A, 32'd0, rd); check("ovr_clr", rd, 32'h3);

    // Reset during RESP; strobe while in reset is ignored
    bus(1'b1, DATA_A, 32'h5A, rd);
    mem_valid_data = 1'b1; mem_rw_data = 1'b0; mem_data_addr = STAT_A;
    @(negedge clk);
    check("rr_resp", 32'(mem_ready_data), 32'd1);
    rst = 1'b1; mem_valid_data = 1'b0; rx_byte = 8'hEE; rx_strobe = 1'b1; tx_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0; rx_strobe = 1'b0; tx_ready = 1'b0;
    check("rr_ready", 32'(mem_ready_data), 32'd0);
    check("rr_rd", mem_data_rd, 32'd0);
    check("rr_txv", 32'(tx_valid), 32'd0);
    bus(1'b0, STAT_A, 32'd0, rd); check("rr_stat", rd, 32'h1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
